// File: rtl/mux_scan.sv
// Registered N-channel mux with manual select and auto-scan dwell modes.
// Optional per-channel scan/select mask is enabled by defining CH_MASK_EN.
module mux_scan #(
    parameter int N     = 8,
    parameter int W     = 1,
    parameter int DWELL = 4,
    parameter int SW    = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            mode,
    input  logic [SW-1:0]   sel,
    input  logic [N*W-1:0]  din,
`ifdef CH_MASK_EN
    input  logic [N-1:0]    ch_mask,
`endif
    output logic [W-1:0]    dout,
    output logic [SW-1:0]   ch,
    output logic            valid,
    output logic            wrap
);

    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0] DLAST = DW'(DWELL - 1);

    typedef enum logic {StIdle, StScan} state_t;

    state_t          state;
    logic [SW-1:0]   ptr;
    logic [DW-1:0]   dcnt;
    logic            wrap_pend;
    logic [N-1:0]    mask;

`ifdef CH_MASK_EN
    assign mask = ch_mask;
`else
    assign mask = '1;
`endif

    function automatic logic [W-1:0] pick(input logic [SW-1:0] idx, input logic [N*W-1:0] d);
        logic [W-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++) begin
            if (idx == SW'(k)) r = d[k*W +: W];
        end
        return r;
    endfunction

    // Next enabled channel strictly above cur, wrapping through 0; cur itself if it is the only one.
    function automatic logic [SW-1:0] next_en(input logic [SW-1:0] cur, input logic [N-1:0] m);
        logic [SW-1:0] r;
        logic          found;
        int            idx;
        r     = cur;
        found = 1'b0;
        for (int i = 1; i <= N; i++) begin
            idx = (int'(cur) + i) % N;
            if (!found && m[SW'(idx)]) begin
                r     = SW'(idx);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    logic [SW-1:0] first_ch;
    logic [SW-1:0] first_nxt;
    logic [SW-1:0] ptr_nxt;
    logic          sel_ok;

    always_comb begin
        first_ch = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (mask[k]) first_ch = SW'(k);
        end
        sel_ok = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (sel == SW'(k)) sel_ok = mask[k];
        end
        first_nxt = next_en(first_ch, mask);
        ptr_nxt   = next_en(ptr, mask);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StIdle;
            ptr       <= '0;
            dcnt      <= '0;
            wrap_pend <= 1'b0;
            dout      <= '0;
            ch        <= '0;
            valid     <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (!(en && mode)) begin
                state     <= StIdle;
                ptr       <= '0;
                dcnt      <= '0;
                wrap_pend <= 1'b0;
                if (en && sel_ok) begin
                    dout  <= pick(sel, din);
                    ch    <= sel;
                    valid <= 1'b1;
                end else begin
                    valid <= 1'b0;
                end
            end else if (!(|mask)) begin
                valid <= 1'b0;
            end else if (state == StIdle) begin
                state <= StScan;
                dout  <= pick(first_ch, din);
                ch    <= first_ch;
                valid <= 1'b1;
                if (DWELL == 1) begin
                    ptr       <= first_nxt;
                    dcnt      <= '0;
                    wrap_pend <= (first_nxt <= first_ch);
                end else begin
                    ptr       <= first_ch;
                    dcnt      <= DW'(1);
                    wrap_pend <= 1'b0;
                end
            end else begin
                dout  <= pick(ptr, din);
                ch    <= ptr;
                valid <= 1'b1;
                // Pointer advance is seen on ch one edge later, so wrap is delayed by a flag.
                wrap  <= wrap_pend;
                if (dcnt == DLAST) begin
                    ptr       <= ptr_nxt;
                    dcnt      <= '0;
                    wrap_pend <= (ptr_nxt <= ptr);
                end else begin
                    dcnt      <= dcnt + 1'b1;
                    wrap_pend <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mux_scan.sv
// Directed self-checking bench for mux_scan (DWELL=4 and DWELL=1 instances).
// Mask scenarios run only when CH_MASK_EN is defined.
module tb_mux_scan;

    localparam int N  = 8;
    localparam int W  = 1;
    localparam int SW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic          mode = 1'b0;
    logic [SW-1:0] sel = '0;
    logic [N*W-1:0] din = '0;
`ifdef CH_MASK_EN
    logic [N-1:0]  ch_mask = '1;
`endif
    logic [W-1:0]  dout, dout1;
    logic [SW-1:0] ch, ch1;
    logic          valid, valid1, wrap, wrap1;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] dv;

    always #5 clk = ~clk;

    mux_scan #(.N(N), .W(W), .DWELL(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .mode  (mode),
        .sel   (sel),
        .din   (din),
`ifdef CH_MASK_EN
        .ch_mask (ch_mask),
`endif
        .dout  (dout),
        .ch    (ch),
        .valid (valid),
        .wrap  (wrap)
    );

    mux_scan #(.N(N), .W(W), .DWELL(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .mode  (mode),
        .sel   (sel),
        .din   (din),
`ifdef CH_MASK_EN
        .ch_mask (ch_mask),
`endif
        .dout  (dout1),
        .ch    (ch1),
        .valid (valid1),
        .wrap  (wrap1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic ed, input logic [SW-1:0] ec,
                             input logic ev, input logic ew);
        n_cmp++;
        assert (dout === ed) else begin
            n_err++;
            $error("FAIL %s dout: got %b expected %b", tag, dout, ed);
        end
        n_cmp++;
        assert (ch === ec) else begin
            n_err++;
            $error("FAIL %s ch: got %0d expected %0d", tag, ch, ec);
        end
        n_cmp++;
        assert (valid === ev) else begin
            n_err++;
            $error("FAIL %s valid: got %b expected %b", tag, valid, ev);
        end
        n_cmp++;
        assert (wrap === ew) else begin
            n_err++;
            $error("FAIL %s wrap: got %b expected %b", tag, wrap, ew);
        end
    endtask

    task automatic check_d1(input string tag, input logic ed, input logic [SW-1:0] ec,
                            input logic ev, input logic ew);
        n_cmp++;
        assert (dout1 === ed) else begin
            n_err++;
            $error("FAIL %s d1 dout: got %b expected %b", tag, dout1, ed);
        end
        n_cmp++;
        assert (ch1 === ec) else begin
            n_err++;
            $error("FAIL %s d1 ch: got %0d expected %0d", tag, ch1, ec);
        end
        n_cmp++;
        assert (valid1 === ev) else begin
            n_err++;
            $error("FAIL %s d1 valid: got %b expected %b", tag, valid1, ev);
        end
        n_cmp++;
        assert (wrap1 === ew) else begin
            n_err++;
            $error("FAIL %s d1 wrap: got %b expected %b", tag, wrap1, ew);
        end
    endtask

    initial begin
        logic [SW-1:0] e;
        logic          v;

        // ch0..7 = 0,0,1,1,0,1,1,0
        dv  = 8'b0110_1100;
        din = dv;

        // Asynchronous reset takes effect without a clock edge.
        #1 rst = 1'b1;
        #1;
        check_out("reset", 1'b0, 3'd0, 1'b0, 1'b0);
        check_d1("reset", 1'b0, 3'd0, 1'b0, 1'b0);
        #10 rst = 1'b0;

        // Manual sweep
        for (int i = 0; i < 8; i++) begin
            en   = 1'b1;
            mode = 1'b0;
            sel  = 3'(i);
            step();
            check_out($sformatf("manual sel=%0d", i), dv[i], 3'(i), 1'b1, 1'b0);
        end

        // Disabled: valid drops, dout/ch hold
        en = 1'b0;
        step();
        check_out("disable", 1'b0, 3'd7, 1'b0, 1'b0);

        // Auto-scan for 40 cycles
        en   = 1'b1;
        mode = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            step();
            e = 3'(((c - 1) / 4) % 8);
            check_out($sformatf("scan c=%0d", c), dv[e], e, 1'b1, c == 33);
            e = 3'((c - 1) % 8);
            check_d1($sformatf("scan c=%0d", c), dv[e], e, 1'b1, (c > 1) && ((c - 1) % 8 == 0));
        end

        en = 1'b0;
        step();
        check_out("idle2", 1'b0, 3'd1, 1'b0, 1'b0);

        // Exit at cycle 10, re-entry after cycle 14 restarts at channel 0
        mode = 1'b1;
        for (int c = 1; c <= 19; c++) begin
            en = !(c >= 11 && c <= 14);
            step();
            if (c <= 10) begin
                e = 3'((c - 1) / 4);
                v = 1'b1;
            end else if (c <= 14) begin
                e = 3'd2;
                v = 1'b0;
            end else if (c <= 18) begin
                e = 3'd0;
                v = 1'b1;
            end else begin
                e = 3'd1;
                v = 1'b1;
            end
            check_out($sformatf("reentry c=%0d", c), dv[e], e, v, 1'b0);
        end

        // Mode 1->0 and sel change on the same edge uses the new sel
        mode = 1'b0;
        sel  = 3'd5;
        step();
        check_out("mode_sel", 1'b1, 3'd5, 1'b1, 1'b0);

        // Reset mid-scan, then restart from channel 0
        mode = 1'b1;
        step();
        step();
        step();
        step();
        step();
        #3 rst = 1'b1;
        #1;
        check_out("rst_mid", 1'b0, 3'd0, 1'b0, 1'b0);
        check_d1("rst_mid", 1'b0, 3'd0, 1'b0, 1'b0);
        #1 rst = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            step();
            e = (c <= 4) ? 3'd0 : 3'd1;
            check_out($sformatf("post_rst c=%0d", c), dv[e], e, 1'b1, 1'b0);
        end

`ifdef CH_MASK_EN
        en = 1'b0;
        step();
        ch_mask = 8'b1000_0101;
        en      = 1'b1;
        mode    = 1'b1;
        for (int c = 1; c <= 13; c++) begin
            step();
            if (c <= 4)       e = 3'd0;
            else if (c <= 8)  e = 3'd2;
            else if (c <= 12) e = 3'd7;
            else              e = 3'd0;
            check_out($sformatf("mask c=%0d", c), dv[e], e, 1'b1, c == 13);
        end
        ch_mask = 8'b0000_0000;
        step();
        check_out("mask_zero", 1'b0, 3'd0, 1'b0, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mux_scan.md
# mux_scan

Parametrised N-channel, W-bit registered multiplexer with a manual select mode and an auto-scan mode. In auto-scan mode an internal channel pointer steps through all channels, dwelling a fixed number of cycles on each. The block replaces the fixed 8:1 combinational mux in datapaths that need time-multiplexed sampling of several sources, for example display scanning or round-robin sensor readout. All outputs are registered, and each output word carries its channel index and a valid strobe.

## Interface
Parameters:
- N, 8, number of input channels (≥2)
- W, 1, bits per channel
- DWELL, 4, cycles spent on each channel in scan mode (≥1)
- SW, $clog2(N), select/index width (derived, not overridden)

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  block enable
- mode  in  1  0 = manual select, 1 = auto-scan
- sel  in  SW  channel select, used in manual mode only
- din  in  N*W  packed inputs; channel k occupies din[k*W +: W]
- ch_mask  in  N  per-channel enable; present only with CH_MASK_EN
- dout  out  W  selected channel data (registered)
- ch  out  SW  index of the channel shown on dout
- valid  out  1  dout/ch hold a fresh sample this cycle
- wrap  out  1  one-cycle pulse when the scan wraps back to the lowest channel

## Operation
- FSM states are IDLE and SCAN. Internal registers: ptr (SW bits) and dcnt (range 0..DWELL-1).
- **IDLE** (en=0 or mode=0): ptr=0, dcnt=0.
  - en=1, mode=0 (manual): each edge sets dout←din[sel], ch←sel, valid←1.
  - Manual with sel≥N: valid←0; dout and ch hold.
  - en=0: valid←0; dout and ch hold; wrap=0.
- **IDLE→SCAN** on the first edge with en=1 and mode=1. That same edge samples channel 0: dout←din[0], ch←0, valid←1, dcnt←1 (or 0 if DWELL=1, with ptr←1).
- **SCAN**, on each edge:
  - dout←din[ptr], ch←ptr, valid←1.
  - If dcnt==DWELL-1: dcnt←0 and ptr advances (N-1 wraps to 0). Otherwise dcnt←dcnt+1.
- Each channel is therefore output on exactly DWELL consecutive cycles, in order 0,1,…,N-1,0,…
- wrap←1 on the edge where ch is loaded with 0 after previously holding N-1. wrap is 0 on the initial entry sample.
- **SCAN→IDLE** on any edge with en=0 or mode=0.
  - The exit edge behaves as the IDLE case for the new inputs: a manual sample if en=1, otherwise valid←0.
  - ptr and dcnt clear to 0, so re-entry always restarts at channel 0.
- din is sampled live every cycle. Changes during a dwell appear on dout one cycle later.

## Timing
- Reset values (asynchronous, immediate): dout=0, ch=0, valid=0, wrap=0, ptr=0, dcnt=0, state=IDLE.
- Latency is 1 cycle from din/sel/mode/en to dout/ch/valid/wrap. There is no combinational input→output path.
- Scan period is N×DWELL cycles. wrap pulses once per period, for 1 cycle.
- Reset asserted mid-scan clears all state within the cycle. After release, the first scan sample is channel 0.
- Simultaneous mode 1→0 and sel change on the same edge: the manual sample uses the new sel.

## Configuration
- Macro: CH_MASK_EN.
- **Defined:** the ch_mask port exists.
  - A scan advance moves ptr to the next channel above the current one with a mask bit of 1, wrapping through 0. wrap fires when the new ptr is ≤ the old ptr.
  - Entry starts at the lowest enabled channel.
  - If every mask bit is 0: valid←0, ptr and dcnt hold, wrap=0.
  - Manual mode with a masked sel: valid←0.
  - A mask bit cleared on the current channel mid-dwell takes effect at the next advance.
- **Undefined:** there is no ch_mask port, all channels are enabled, and behaviour is exactly as in Operation.

## Test plan
All scenarios use N=8, W=1, DWELL=4, din=8'b0110_1100 (ch0..7 = 0,0,1,1,0,1,1,0).
- **Reset:** assert rst mid-cycle → dout=0, ch=0, valid=0, wrap=0 immediately.
- **Manual sweep:** en=1, mode=0, sel=0..7 held 1 cycle each → one cycle later dout=0,0,1,1,0,1,1,0, ch tracks sel, valid=1.
- **Scan:** en=1, mode=1 for 40 cycles → ch=0 for cycles 1-4, 1 for cycles 5-8, …, 7 for cycles 29-32, 0 from cycle 33. wrap=1 only in cycle 33. dout matches din[ch].
- **Exit/re-entry:** drop en in cycle 10 (ch=2), re-raise in cycle 14 → valid=0 for cycles 11-14, then ch=0 with 4 fresh dwell cycles.
- **Mask (CH_MASK_EN):** ch_mask=8'b1000_0101 → scan order 0,2,7,0 at 4 cycles each; wrap on the 7→0 advance. Then ch_mask=0 → valid=0, ch holds.
- **DWELL=1:** ch increments every cycle and wrap pulses every 8 cycles.
